// File: rtl/sort_loader.sv
// rtl/sort_loader.sv - packs a serial word stream into the bubble-sorter input array and paces batches
module sort_loader #(
    parameter int DATA_N = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_rdy,
    output logic [DATA_W-1:0] data_in [0:DATA_N-1],
    output logic              start_sort,
    input  logic              out_vld,
    output logic              busy,
    output logic              batch_done
);

    localparam int CNT_W = $clog2(DATA_N + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_N - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wr_idx;
    logic [CNT_W-1:0] beat_cnt;
    logic             accept;

    // in_rdy is a register, so accept never depends combinationally on in_vld reaching in_rdy
    assign accept = in_vld && in_rdy;

    // batch_done must coincide with the final sorter beat, so it is decoded rather than registered
    assign batch_done = (state == WAIT) && out_vld && (beat_cnt == LAST_IDX);

    // batch sequencer: fill array, pulse start, then hold until the sorter has drained the batch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FILL;
            wr_idx     <= '0;
            beat_cnt   <= '0;
            in_rdy     <= 1'b0;
            start_sort <= 1'b0;
            busy       <= 1'b0;
            for (int i = 0; i < DATA_N; i++) begin
                data_in[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    in_rdy     <= 1'b1;
                    start_sort <= 1'b0;
                    busy       <= 1'b0;
                    if (accept) begin
                        for (int i = 0; i < DATA_N; i++) begin
                            if (wr_idx == CNT_W'(i)) begin
                                data_in[i] <= in_data;
                            end
                        end
                        if (wr_idx == LAST_IDX) begin
                            wr_idx     <= '0;
                            state      <= START;
                            in_rdy     <= 1'b0;
                            start_sort <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                START: begin
                    state      <= WAIT;
                    beat_cnt   <= '0;
                    in_rdy     <= 1'b0;
                    start_sort <= 1'b0;
                    busy       <= 1'b1;
                end
                WAIT: begin
                    start_sort <= 1'b0;
                    if (out_vld) begin
                        if (beat_cnt == LAST_IDX) begin
                            beat_cnt <= '0;
                            state    <= FILL;
                            in_rdy   <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= FILL;
                    wr_idx     <= '0;
                    beat_cnt   <= '0;
                    in_rdy     <= 1'b0;
                    start_sort <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_loader.sv
// tb/tb_sort_loader.sv - randomized self-checking bench for sort_loader against a batch-level model
module tb_sort_loader;
    localparam int N = 4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n, in_vld, in_rdy, start_sort, out_vld, busy, batch_done;
    logic [W-1:0] in_data;
    logic [W-1:0] data_in [0:N-1];

    always #5 clk = ~clk;

    sort_loader #(.DATA_N(N), .DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
        .data_in(data_in), .start_sort(start_sort), .out_vld(out_vld), .busy(busy),
        .batch_done(batch_done)
    );

    int checks = 0;
    int errors = 0;

    // batch-level reference: words collected so far, a pending start, and beats still owed by the sorter
    logic [W-1:0] m_arr [N];
    int           m_acc, m_beats, n_start_obs, n_start_exp;
    bit           m_live, m_pulse, m_sorting, m_took;
    logic [3:0]   s_ctl, e_ctl;          // {in_rdy, start_sort, busy, batch_done}
    logic [N*W-1:0] s_flat, e_flat;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_arr[i] = '0;
        m_acc = 0; m_beats = 0; m_live = 0; m_pulse = 0; m_sorting = 0;
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic o, input logic r);
        in_vld = v; in_data = d; out_vld = o; rst_n = r;
        #4;
        s_ctl = {in_rdy, start_sort, busy, batch_done};
        for (int i = 0; i < N; i++) begin
            s_flat[i*W +: W] = data_in[i];
            e_flat[i*W +: W] = m_arr[i];
        end
        e_ctl = {m_live && !m_pulse && !m_sorting, m_pulse, m_pulse || m_sorting,
                 m_sorting && o && (m_beats == N - 1)};
        if (start_sort === 1'b1) n_start_obs++;
        if (m_pulse) n_start_exp++;
        m_took = r && v && e_ctl[3];
        @(posedge clk);
        #1;
        if (!r) begin
            model_reset();
        end else begin
            m_live = 1;
            if (m_pulse) begin
                m_pulse = 0; m_sorting = 1; m_beats = 0;
            end else if (m_sorting && o) begin
                m_beats++;
                if (m_beats == N) m_sorting = 0;
            end
            if (m_took) begin
                m_arr[m_acc] = d;
                m_acc++;
                if (m_acc == N) begin
                    m_acc = 0; m_pulse = 1;
                end
            end
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0; in_vld = 1'b1; in_data = 4'($urandom); out_vld = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) begin
            step(1'b1, 4'($urandom), 1'b0, 1'b0);
            checks++; if (s_ctl !== 4'b0000) begin errors++; $display("FAIL reset_ctl got %b want %b", s_ctl, 4'b0000); end
            checks++; if (s_flat !== '0) begin errors++; $display("FAIL reset_data got %h want 0", s_flat); end
        end
        step(1'b0, 4'd0, 1'b0, 1'b1);
        checks++; if (s_ctl !== e_ctl) begin errors++; $display("FAIL reset_release got %b want %b", s_ctl, e_ctl); end
        step(1'b0, 4'd0, 1'b0, 1'b1);
        checks++; if (s_ctl[3] !== 1'b1) begin errors++; $display("FAIL reset_rdy_rise got %b want 1", s_ctl[3]); end
    endtask

    task automatic test_single_batch();
        logic [W-1:0] w [4] = '{4'd3, 4'd1, 4'd2, 4'd0};
        int beats = 0, guard = 0;
        logic o;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, w[i], 1'b0, 1'b1);
            checks++; if (s_ctl !== e_ctl) begin errors++; $display("FAIL single_fill_ctl got %b want %b", s_ctl, e_ctl); end
        end
        step(1'b0, 4'd0, 1'b0, 1'b1);
        checks++; if (s_ctl !== 4'b0110) begin errors++; $display("FAIL single_start got %b want 0110", s_ctl); end
        checks++; if (s_flat !== 16'h0213) begin errors++; $display("FAIL single_data got %h want 0213", s_flat); end
        while (beats < N && guard < 40) begin
            o = 1'($urandom_range(1));
            step(1'b0, 4'd0, o, 1'b1);
            checks++; if (s_ctl !== e_ctl) begin errors++; $display("FAIL single_wait_ctl got %b want %b", s_ctl, e_ctl); end
            if (o) beats++;
            guard++;
        end
        checks++; if (beats != N) begin errors++; $display("FAIL single_timeout got %0d beats want %0d", beats, N); end
        checks++; if (s_ctl[0] !== 1'b1) begin errors++; $display("FAIL single_done got %b want 1", s_ctl[0]); end
        step(1'b0, 4'd0, 1'b0, 1'b1);
        checks++; if (s_ctl !== 4'b1000) begin errors++; $display("FAIL single_refill got %b want 1000", s_ctl); end
        checks++; if (s_flat !== 16'h0213) begin errors++; $display("FAIL single_hold got %h want 0213", s_flat); end
    endtask

    task automatic test_bubbles();
        int starts0 = n_start_obs, guard = 0;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) step(1'b1, 4'(5 + k / 2), 1'b0, 1'b1);
            else            step(1'b0, 4'($urandom), 1'b0, 1'b1);
            checks++; if (s_ctl !== e_ctl) begin errors++; $display("FAIL bubble_fill got %b want %b", s_ctl, e_ctl); end
        end
        while ((m_pulse || m_sorting) && guard < 60) begin
            step(1'b0, 4'($urandom), 1'($urandom_range(1)), 1'b1);
            checks++; if (s_ctl !== e_ctl) begin errors++; $display("FAIL bubble_wait got %b want %b", s_ctl, e_ctl); end
            checks++; if (s_flat !== 16'h8765) begin errors++; $display("FAIL bubble_data got %h want 8765", s_flat); end
            guard++;
        end
        checks++; if (n_start_obs - starts0 != 1) begin errors++; $display("FAIL bubble_starts got %0d want 1", n_start_obs - starts0); end
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] sent;
        int guard = 0;
        for (int i = 0; i < N; i++) begin
            sent[i*W +: W] = 4'($urandom);
            step(1'b1, sent[i*W +: W], 1'b0, 1'b1);
            checks++; if (s_ctl !== e_ctl) begin errors++; $display("FAIL bp_fill got %b want %b", s_ctl, e_ctl); end
        end
        step(1'b1, 4'd9, 1'b0, 1'b1);
        checks++; if (s_ctl !== 4'b0110) begin errors++; $display("FAIL bp_start got %b want 0110", s_ctl); end
        while (m_sorting && guard < 60) begin
            step(1'b1, (guard % 2 == 0) ? 4'd9 : 4'd10, 1'($urandom_range(1)), 1'b1);
            checks++; if (s_ctl !== e_ctl) begin errors++; $display("FAIL bp_wait got %b want %b", s_ctl, e_ctl); end
            checks++; if (s_flat !== sent) begin errors++; $display("FAIL bp_frozen got %h want %h", s_flat, sent); end
            guard++;
        end
        step(1'b1, 4'd9, 1'b0, 1'b1);
        checks++; if (s_ctl[3] !== 1'b1) begin errors++; $display("FAIL bp_rdy got %b want 1", s_ctl[3]); end
        step(1'b1, 4'd10, 1'b0, 1'b1);
        checks++; if (s_flat[W-1:0] !== 4'd9) begin errors++; $display("FAIL bp_word9 got %0d want 9", s_flat[W-1:0]); end
        checks++; if (s_flat !== e_flat) begin errors++; $display("FAIL bp_data got %h want %h", s_flat, e_flat); end
        guard = 0;
        while ((m_acc != 0 || m_pulse || m_sorting) && guard < 60) begin
            step(1'b1, 4'($urandom), 1'($urandom_range(1)), 1'b1);
            checks++; if (s_ctl !== e_ctl) begin errors++; $display("FAIL bp_drain got %b want %b", s_ctl, e_ctl); end
            guard++;
        end
    endtask

    task automatic test_out_vld();
        for (int i = 0; i < N; i++) begin
            step(1'b1, 4'($urandom), 1'b1, 1'b1);
            checks++; if (s_ctl !== e_ctl) begin errors++; $display("FAIL ov_fill got %b want %b", s_ctl, e_ctl); end
        end
        step(1'b0, 4'd0, 1'b1, 1'b1);
        checks++; if (s_ctl !== 4'b0110) begin errors++; $display("FAIL ov_start got %b want 0110", s_ctl); end
        for (int i = 0; i < N; i++) begin
            step(1'b0, 4'd0, 1'b1, 1'b1);
            checks++; if (s_ctl[0] !== (i == N - 1)) begin errors++; $display("FAIL ov_done_%0d got %b want %b", i, s_ctl[0], i == N - 1); end
        end
        step(1'b0, 4'd0, 1'b1, 1'b1);
        checks++; if (s_ctl !== 4'b1000) begin errors++; $display("FAIL ov_extra got %b want 1000", s_ctl); end
        step(1'b0, 4'd0, 1'b0, 1'b1);
        checks++; if (s_ctl !== 4'b1000) begin errors++; $display("FAIL ov_idle got %b want 1000", s_ctl); end
    endtask

    task automatic test_reset_mid();
        int starts0, guard = 0;
        step(1'b1, 4'($urandom), 1'b0, 1'b1);
        step(1'b1, 4'($urandom), 1'b0, 1'b1);
        step(1'b1, 4'($urandom), 1'b0, 1'b0);
        starts0 = n_start_obs;
        for (int w = 1; w <= 4; w++) begin
            m_took = 0;
            while (!m_took && guard < 20) begin
                step(1'b1, 4'(w), 1'b0, 1'b1);
                checks++; if (s_ctl !== e_ctl) begin errors++; $display("FAIL mid_fill got %b want %b", s_ctl, e_ctl); end
                checks++; if (s_ctl[2] !== 1'b0) begin errors++; $display("FAIL mid_early_start got %b want 0", s_ctl[2]); end
                guard++;
            end
        end
        checks++; if (guard >= 20) begin errors++; $display("FAIL mid_timeout got %0d cycles want <20", guard); end
        step(1'b0, 4'd0, 1'b0, 1'b1);
        checks++; if (s_ctl !== 4'b0110) begin errors++; $display("FAIL mid_start got %b want 0110", s_ctl); end
        checks++; if (s_flat !== 16'h4321) begin errors++; $display("FAIL mid_data got %h want 4321", s_flat); end
        guard = 0;
        while (m_sorting && guard < 60) begin
            step(1'b0, 4'd0, 1'($urandom_range(1)), 1'b1);
            checks++; if (s_ctl !== e_ctl) begin errors++; $display("FAIL mid_wait got %b want %b", s_ctl, e_ctl); end
            guard++;
        end
        checks++; if (n_start_obs - starts0 != 1) begin errors++; $display("FAIL mid_starts got %0d want 1", n_start_obs - starts0); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(3) != 0), 4'($urandom), 1'($urandom_range(1)), 1'($urandom_range(60) != 0));
            checks++; if (s_ctl !== e_ctl) begin errors++; $display("FAIL rand_ctl c%0d got %b want %b", c, s_ctl, e_ctl); end
            checks++; if (s_flat !== e_flat) begin errors++; $display("FAIL rand_data c%0d got %h want %h", c, s_flat, e_flat); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_start_obs = 0;
        n_start_exp = 0;
        test_reset();
        test_single_batch();
        test_bubbles();
        test_backpressure();
        test_out_vld();
        test_reset_mid();
        test_random();
        checks++; if (n_start_obs != n_start_exp) begin errors++; $display("FAIL start_total got %0d want %0d", n_start_obs, n_start_exp); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
